// File: rtl/sp_ram_be_init.sv
// Single-port RAM with byte enables, RD_LAT-cycle registered read and a clear engine.
// Optional per-byte even parity is enabled by defining SP_RAM_PARITY_EN.
module sp_ram_be_init #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int RAM_DEPTH = 16,
  parameter int RD_LAT    = 1,
  parameter int RDW_MODE  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                we,
  input  logic                oe,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  input  logic                clr,
`ifdef SP_RAM_PARITY_EN
  input  logic                perr_inject,
  output logic [DATA_W/8-1:0] rd_perr,
`endif
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                busy,
  output logic                addr_err
);

  localparam int NB = DATA_W / 8;
  localparam int IW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A  = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(RAM_DEPTH - 1);
`ifdef SP_RAM_PARITY_EN
  localparam int PW = DATA_W + NB;
`else
  localparam int PW = DATA_W;
`endif

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_CLEAR} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [RAM_DEPTH];

  logic              in_range, acc, wr_acc, rd_acc;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] old_word, merged, rd_word;
  logic              s1_v_d, s1_e_d;
  logic [PW-1:0]     s1_pl_d;
  logic              p_v, p_e;
  logic [PW-1:0]     p_pl;
  logic              rvalid_q, rvalid_d, addr_err_q, addr_err_d;
  logic [PW-1:0]     rpl_q, rpl_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT, S_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign in_range = ({1'b0, addr} < DEPTH_A);
  assign idx      = addr[IW-1:0];
  assign acc      = !busy && cs && (we || oe);
  assign wr_acc   = acc && we && in_range;
  assign rd_acc   = acc && oe;
  assign old_word = mem[idx];

  // merged doubles as the write word: be=0 leaves the stored word unchanged
  always_comb begin
    merged = old_word;
    for (int i = 0; i < NB; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    rd_word = old_word;
    if (!in_range)                    rd_word = '0;
    else if (RDW_MODE == 1 && wr_acc) rd_word = merged;
  end

  always_ff @(posedge clk) begin
    if (busy)        mem[cnt_q] <= '0;
    else if (wr_acc) mem[idx]   <= merged;
  end

`ifdef SP_RAM_PARITY_EN
  logic [NB-1:0] par_mem [RAM_DEPTH];
  logic [NB-1:0] par_old, par_new, par_rd, perr_s0;

  assign par_old = par_mem[idx];

  always_comb begin
    par_new = par_old;
    perr_s0 = '0;
    for (int i = 0; i < NB; i++)
      if (be[i]) par_new[i] = (^wdata[8*i +: 8]) ^ perr_inject;
    par_rd = (RDW_MODE == 1 && wr_acc) ? par_new : par_old;
    for (int i = 0; i < NB; i++)
      perr_s0[i] = in_range & ((^rd_word[8*i +: 8]) ^ par_rd[i]);
  end

  always_ff @(posedge clk) begin
    if (busy)        par_mem[cnt_q] <= '0;
    else if (wr_acc) par_mem[idx]   <= par_new;
  end

  assign s1_pl_d = {perr_s0, rd_word};
  assign rd_perr = rpl_q[PW-1:DATA_W];
`else
  assign s1_pl_d = rd_word;
`endif

  // a write-only out-of-range access still travels the pipe to time addr_err
  assign s1_v_d = rd_acc;
  assign s1_e_d = acc && !in_range;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          s1_v_q, s1_e_q;
      logic [PW-1:0] s1_pl_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_v_q  <= 1'b0;
          s1_e_q  <= 1'b0;
          s1_pl_q <= '0;
        end else begin
          s1_v_q  <= s1_v_d;
          s1_e_q  <= s1_e_d;
          s1_pl_q <= s1_pl_d;
        end
      end
      assign p_v  = s1_v_q;
      assign p_e  = s1_e_q;
      assign p_pl = s1_pl_q;
    end else begin : g_lat1
      assign p_v  = s1_v_d;
      assign p_e  = s1_e_d;
      assign p_pl = s1_pl_d;
    end
  endgenerate

  always_comb begin
    rvalid_d   = p_v;
    addr_err_d = p_e;
    rpl_d      = p_v ? p_pl : rpl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
      rpl_q      <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      addr_err_q <= addr_err_d;
      rpl_q      <= rpl_d;
    end
  end

  assign rvalid   = rvalid_q;
  assign addr_err = addr_err_q;
  assign rdata    = rpl_q[DATA_W-1:0];

endmodule

// File: doc/sp_ram_be_init.md
Name: sp_ram_be_init

Overview:
Parametrised single-port synchronous RAM. It adds per-byte write enables, a configurable registered read latency and a selectable read-during-write mode. A hardware clear engine zeroes the array after reset and on request. It serves as the general-purpose scratch and buffer memory for datapath blocks, and replaces fixed-width 8-bit single-port memories.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 4, address width in bits.
RAM_DEPTH, 16, number of words; 1 <= RAM_DEPTH <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
RDW_MODE, 0, read-during-write mode: 0 = old data (read-first), 1 = new merged data (write-first).

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst_n  input  1  asynchronous active-low reset.
cs  input  1  chip select; qualifies every access.
we  input  1  write enable.
oe  input  1  output enable; requests a read.
addr  input  ADDR_W  word address.
wdata  input  DATA_W  write data.
be  input  DATA_W/8  byte enables; bit i enables wdata[8i+7:8i].
clr  input  1  single-cycle pulse that starts a full-array clear.
rdata  output  DATA_W  read data.
rvalid  output  1  one-cycle pulse; rdata is valid in that cycle.
busy  output  1  high while the clear engine owns the array.
addr_err  output  1  one-cycle pulse: an access was accepted with addr >= RAM_DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): rdata=0, rvalid=0, addr_err=0, busy=1, read pipeline flushed, FSM=INIT, sweep counter=0.
- FSM states are INIT, IDLE and CLEAR.
  - INIT: entered from reset. Writes 0 to word[cnt] each cycle; cnt increments from 0 to RAM_DEPTH-1. After the write to the last word, goes to IDLE.
  - INIT lasts exactly RAM_DEPTH cycles after rst_n deasserts. busy drops in the cycle after the last word is written.
  - IDLE: busy=0; accesses are accepted. clr=1 goes to CLEAR with cnt=0.
  - CLEAR: identical sweep to INIT, then returns to IDLE.
- While busy=1, cs/we/oe are ignored: no write, no rvalid, no addr_err. clr is also ignored while busy=1.
- If clr and an access occur in the same IDLE cycle, the access completes and CLEAR starts on the next cycle.
- Write: accepted when busy=0, cs=1, we=1 and addr < RAM_DEPTH. Only bytes with be[i]=1 are updated. be=0 means no change to the array.
- Read: accepted when busy=0, cs=1 and oe=1.
  - rdata and rvalid update RD_LAT cycles after the accept edge.
  - rdata holds its last value when rvalid=0.
  - Back-to-back reads give one result per cycle; there are no bubbles.
- Read-during-write (cs=1, we=1, oe=1): returns a read of the same address.
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the pre-write word with the bytes enabled by be replaced by wdata.
- Out of range (addr >= RAM_DEPTH, access accepted):
  - A write is dropped.
  - A read returns rdata=0 with rvalid=1.
  - addr_err pulses with the same latency as rvalid; a write-only access uses RD_LAT as its latency.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced. A sweep in progress restarts from word 0. Array contents outside the sweep are undefined until INIT completes.

Optional Feature:
Macro SP_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and written together with that byte.
  - New input perr_inject (1 bit): when high on a write, the stored parity of the enabled bytes is inverted.
  - New output rd_perr (DATA_W/8 bits), aligned with rvalid: bit i=1 means byte i failed its parity check.
  - Clearing writes parity 0, which is consistent with the data value 0.
  - Out-of-range reads return rd_perr=0.
  - Reset value of rd_perr is 0.
- Undefined: no parity storage, and no perr_inject or rd_perr ports.

Test Plan:
- Reset and INIT (DATA_W=32, RAM_DEPTH=16): release rst_n -> busy=1 for 16 cycles, then 0. Reads of addresses 0..15 -> rdata=0x00000000 with rvalid after RD_LAT cycles.
- Byte enables: write 0xAABBCCDD to addr 3 with be=4'hF, then 0x11223344 with be=4'b0101 -> read of addr 3 returns 0xAA22CC44.
- Latency and throughput with RD_LAT=2: reads of addr 1,2,3 on consecutive cycles -> three consecutive rvalid pulses starting 2 cycles after the first read, with data in order.
- Read-during-write at addr 5 holding 0x0, writing 0xFFFFFFFF with be=4'b0011 and oe=1:
  - RDW_MODE=0 -> rdata=0x00000000.
  - RDW_MODE=1 -> rdata=0x0000FFFF.
- Clear and range errors:
  - clr in IDLE -> busy=1 for 16 cycles; accesses during that window produce no rvalid; afterwards all words read 0.
  - Read of addr 20 with ADDR_W=5, RAM_DEPTH=16 -> rdata=0 with rvalid=1 and addr_err=1.
- Parity and reset abort:
  - With SP_RAM_PARITY_EN: write addr 7 with perr_inject=1 and be=4'b1000 -> read of addr 7 returns rd_perr=4'b1000.
  - Assert rst_n during a RD_LAT=2 read -> no rvalid, and busy returns to 1.
